// File: rtl/maquina_cafe_pkg.sv
// ============================================================================
// maquina_cafe_pkg : shared types and constants for the coffee-machine controller
// Rev 1.0
// ============================================================================
`default_nettype none

package maquina_cafe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AGUA   = 3'd1,
        ST_CAFE   = 3'd2,
        ST_LECHE  = 3'd3,
        ST_CHOCO  = 3'd4,
        ST_AZUCAR = 3'd5,
        ST_LISTO  = 3'd6
    } state_t;

    localparam logic [6:0] PRICE_E    = 7'd6;
    localparam logic [6:0] PRICE_L    = 7'd8;
    localparam logic [6:0] PRICE_X    = 7'd5;
    localparam logic [6:0] PRICE_M    = 7'd10;
    localparam logic [6:0] C_VAL      = 7'd1;
    localparam logic [6:0] Q_VAL      = 7'd5;
    localparam logic [6:0] CREDIT_MAX = 7'd99;

    // Step-mask bit order {azucar, choco, leche, cafe, agua}
    localparam logic [4:0] STEP_AGUA   = 5'b00001;
    localparam logic [4:0] STEP_CAFE   = 5'b00010;
    localparam logic [4:0] STEP_LECHE  = 5'b00100;
    localparam logic [4:0] STEP_CHOCO  = 5'b01000;
    localparam logic [4:0] STEP_AZUCAR = 5'b10000;

    localparam logic [4:0] RECIPE_E = STEP_AGUA | STEP_CAFE;
    localparam logic [4:0] RECIPE_L = STEP_AGUA | STEP_CAFE | STEP_LECHE;
    localparam logic [4:0] RECIPE_X = STEP_AGUA | STEP_CHOCO;
    localparam logic [4:0] RECIPE_M = STEP_AGUA | STEP_CAFE | STEP_LECHE | STEP_CHOCO;

    function automatic state_t next_step(input state_t cur, input logic [4:0] mask);
        logic [4:0] done;
        logic [4:0] rem;
        state_t     nxt;
        case (cur)
            ST_AGUA:  done = 5'b00001;
            ST_CAFE:  done = 5'b00011;
            ST_LECHE: done = 5'b00111;
            ST_CHOCO: done = 5'b01111;
            default:  done = 5'b11111;
        endcase
        rem = mask & ~done;
        if (rem[1])      nxt = ST_CAFE;
        else if (rem[2]) nxt = ST_LECHE;
        else if (rem[3]) nxt = ST_CHOCO;
        else if (rem[4]) nxt = ST_AZUCAR;
        else             nxt = ST_LISTO;
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/maquina_cafe_teorica_fsm_hex7seg.sv
// ============================================================================
// hex7seg : BCD digit to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}
// Rev 1.0
// ============================================================================
`default_nettype none

module hex7seg (
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_digit)
            4'd0:    o_seg = 7'b1000000;
            4'd1:    o_seg = 7'b1111001;
            4'd2:    o_seg = 7'b0100100;
            4'd3:    o_seg = 7'b0110000;
            4'd4:    o_seg = 7'b0011001;
            4'd5:    o_seg = 7'b0010010;
            4'd6:    o_seg = 7'b0000010;
            4'd7:    o_seg = 7'b1111000;
            4'd8:    o_seg = 7'b0000000;
            4'd9:    o_seg = 7'b0010000;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/maquina_cafe_teorica_fsm.sv
// ============================================================================
// maquina_cafe_teorica_fsm : coin credit, drink selection and ingredient sequencing
// Rev 1.0
// ============================================================================
`default_nettype none

module maquina_cafe_teorica_fsm
    import maquina_cafe_pkg::*;
#(
    parameter int STEP_CYCLES  = 4,
    parameter int READY_CYCLES = 4
) (
    input  logic       clk_50Mhz,
    input  logic       rst,
    input  logic       e,
    input  logic       l,
    input  logic       x,
    input  logic       m,
    input  logic       a,
    input  logic       C,
    input  logic       Q,
    output logic       bebidaLista,
    output logic       agua,
    output logic       cafe,
    output logic       leche,
    output logic       choco,
    output logic       azucar,
    output logic [6:0] hex1,
    output logic [6:0] hex2
);

    localparam int CNT_MAX = (STEP_CYCLES > READY_CYCLES) ? STEP_CYCLES : READY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [4:0]         r_mask;
    logic [6:0]         r_credit;
    logic               r_e_q, r_l_q, r_x_q, r_m_q, r_c_q, r_q_q;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [4:0]         w_mask_nxt;
    logic [6:0]         w_credit_nxt;
    logic [6:0]         w_price;
    logic [4:0]         w_recipe;
    logic               w_sel_valid;
    logic               w_accept;
    logic [6:0]         w_debited;
    logic [6:0]         w_coin;
    logic [6:0]         w_sum;
    logic [3:0]         w_tens;
    logic [3:0]         w_units;

    wire w_e_rise = e & ~r_e_q;
    wire w_l_rise = l & ~r_l_q;
    wire w_x_rise = x & ~r_x_q;
    wire w_m_rise = m & ~r_m_q;
    wire w_c_rise = C & ~r_c_q;
    wire w_q_rise = Q & ~r_q_q;

    always_comb begin
        w_sel_valid = 1'b1;
        if (w_e_rise) begin
            w_price  = PRICE_E;
            w_recipe = RECIPE_E;
        end else if (w_l_rise) begin
            w_price  = PRICE_L;
            w_recipe = RECIPE_L;
        end else if (w_x_rise) begin
            w_price  = PRICE_X;
            w_recipe = RECIPE_X;
        end else if (w_m_rise) begin
            w_price  = PRICE_M;
            w_recipe = RECIPE_M;
        end else begin
            w_price     = '0;
            w_recipe    = '0;
            w_sel_valid = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_mask;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid && (r_credit >= w_price)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_AGUA;
                    w_cnt_nxt   = '0;
                    w_mask_nxt  = w_recipe | (a ? STEP_AZUCAR : 5'b00000);
                end
            end
            ST_LISTO: begin
                if (r_cnt == CNT_W'(READY_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                if (r_cnt == CNT_W'(STEP_CYCLES - 1)) begin
                    w_state_nxt = next_step(r_state, r_mask);
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    // Debit first, then add coins; a coin batch overflowing 99 is dropped whole.
    always_comb begin
        w_debited    = w_accept ? (r_credit - w_price) : r_credit;
        w_coin       = (w_c_rise ? C_VAL : 7'd0) + (w_q_rise ? Q_VAL : 7'd0);
        w_sum        = w_debited + w_coin;
        w_credit_nxt = (w_sum <= CREDIT_MAX) ? w_sum : w_debited;
    end

    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_credit    <= '0;
            r_e_q       <= 1'b0;
            r_l_q       <= 1'b0;
            r_x_q       <= 1'b0;
            r_m_q       <= 1'b0;
            r_c_q       <= 1'b0;
            r_q_q       <= 1'b0;
            agua        <= 1'b0;
            cafe        <= 1'b0;
            leche       <= 1'b0;
            choco       <= 1'b0;
            azucar      <= 1'b0;
            bebidaLista <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mask      <= w_mask_nxt;
            r_credit    <= w_credit_nxt;
            r_e_q       <= e;
            r_l_q       <= l;
            r_x_q       <= x;
            r_m_q       <= m;
            r_c_q       <= C;
            r_q_q       <= Q;
            agua        <= (w_state_nxt == ST_AGUA);
            cafe        <= (w_state_nxt == ST_CAFE);
            leche       <= (w_state_nxt == ST_LECHE);
            choco       <= (w_state_nxt == ST_CHOCO);
            azucar      <= (w_state_nxt == ST_AZUCAR);
            bebidaLista <= (w_state_nxt == ST_LISTO);
        end
    end

    assign w_tens  = 4'(r_credit / 7'd10);
    assign w_units = 4'(r_credit % 7'd10);

    hex7seg u_hex_tens  (.i_digit(w_tens),  .o_seg(hex1));
    hex7seg u_hex_units (.i_digit(w_units), .o_seg(hex2));

endmodule

`default_nettype wire

// File: tb/tb_maquina_cafe_teorica_fsm.sv
// ============================================================================
// tb_maquina_cafe_teorica_fsm : directed-vector bench for the vending controller
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_maquina_cafe_teorica_fsm;

    logic       clk_50Mhz = 1'b0;
    logic       rst = 1'b0;
    logic       e = 1'b0, l = 1'b0, x = 1'b0, m = 1'b0, a = 1'b0, C = 1'b0, Q = 1'b0;
    logic       bebidaLista, agua, cafe, leche, choco, azucar;
    logic [6:0] hex1, hex2;

    int n_vec  = 0;
    int n_fail = 0;

    // Output vector order {bebidaLista, azucar, choco, leche, cafe, agua}
    localparam logic [5:0] O_IDLE   = 6'b000000;
    localparam logic [5:0] O_AGUA   = 6'b000001;
    localparam logic [5:0] O_CAFE   = 6'b000010;
    localparam logic [5:0] O_LECHE  = 6'b000100;
    localparam logic [5:0] O_CHOCO  = 6'b001000;
    localparam logic [5:0] O_AZUCAR = 6'b010000;
    localparam logic [5:0] O_LISTO  = 6'b100000;

    maquina_cafe_teorica_fsm #(.STEP_CYCLES(4), .READY_CYCLES(4)) dut (
        .clk_50Mhz  (clk_50Mhz),
        .rst        (rst),
        .e          (e),
        .l          (l),
        .x          (x),
        .m          (m),
        .a          (a),
        .C          (C),
        .Q          (Q),
        .bebidaLista(bebidaLista),
        .agua       (agua),
        .cafe       (cafe),
        .leche      (leche),
        .choco      (choco),
        .azucar     (azucar),
        .hex1       (hex1),
        .hex2       (hex2)
    );

    always #10 clk_50Mhz = ~clk_50Mhz;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50Mhz);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, bebidaLista, azucar, choco, leche, cafe, agua}, {26'd0, exp});
    endtask

    task automatic chk_credit(input string tag, input int cr);
        chk(tag, {18'd0, hex1, hex2}, {18'd0, seg(cr / 10), seg(cr % 10)});
    endtask

    task automatic phase(input string tag, input logic [5:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            chk_outs(tag, exp);
            tick();
        end
    endtask

    task automatic coin_c();
        C = 1'b1; tick(); tick(); C = 1'b0; tick();
    endtask

    task automatic coin_q();
        Q = 1'b1; tick(); tick(); Q = 1'b0; tick();
    endtask

    initial begin
        #35;
        chk_outs("reset_outs", O_IDLE);
        chk_credit("reset_hex", 0);
        rst = 1'b1;
        tick();

        coin_c(); coin_q(); coin_c();
        chk_credit("credit_7", 7);
        chk("hex2_7", {25'd0, hex2}, 32'h78);

        e = 1'b1; tick(); e = 1'b0;
        chk_credit("espresso_debit", 1);
        phase("esp_agua",  O_AGUA,  4);
        phase("esp_cafe",  O_CAFE,  4);
        phase("esp_listo", O_LISTO, 4);
        chk_outs("esp_idle", O_IDLE);
        chk_credit("esp_credit", 1);

        m = 1'b1; tick(); m = 1'b0;
        phase("insuff_idle", O_IDLE, 3);
        chk_credit("insuff_credit", 1);

        coin_q(); coin_q();
        for (int i = 0; i < 4; i++) coin_c();
        chk_credit("credit_15", 15);

        a = 1'b1; m = 1'b1; tick(); m = 1'b0; a = 1'b0;
        chk_credit("mocha_debit", 5);
        phase("moc_agua", O_AGUA, 4);
        Q = 1'b1;
        phase("moc_cafe_a", O_CAFE, 2);
        Q = 1'b0;
        phase("moc_cafe_b", O_CAFE, 2);
        chk_credit("moc_midcoin", 10);
        e = 1'b1;
        phase("moc_leche",  O_LECHE,  4);
        e = 1'b0;
        phase("moc_choco",  O_CHOCO,  4);
        phase("moc_azucar", O_AZUCAR, 4);
        phase("moc_listo",  O_LISTO,  4);
        chk_outs("moc_idle", O_IDLE);
        chk_credit("moc_credit", 10);

        for (int i = 0; i < 17; i++) coin_q();
        chk_credit("credit_95", 95);
        coin_c(); coin_c();
        chk_credit("credit_97", 97);
        coin_q();
        chk_credit("sat_97", 97);

        tick();
        e = 1'b1; tick(); e = 1'b0;
        phase("abort_agua", O_AGUA, 2);
        rst = 1'b0; #2;
        chk_outs("abort_outs", O_IDLE);
        chk_credit("abort_credit", 0);
        tick(); rst = 1'b1; tick();

        coin_q(); coin_q();
        chk_credit("credit_10", 10);
        e = 1'b1; l = 1'b1; tick(); e = 1'b0; l = 1'b0;
        chk_credit("prio_debit", 4);
        phase("prio_agua",  O_AGUA,  4);
        phase("prio_cafe",  O_CAFE,  4);
        phase("prio_listo", O_LISTO, 4);
        chk_outs("prio_idle", O_IDLE);
        chk_credit("prio_credit", 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/maquina_cafe_teorica_fsm.md
# maquina_cafe_teorica_fsm

Coin-operated beverage vending controller. It accepts 100- and 500-colón coins, keeps a credit balance shown on two 7-segment displays, and accepts a drink selection when credit covers the price. It then sequences the ingredient valves (water, coffee, milk, chocolate, sugar) and signals when the drink is ready. It is the top-level control block of the coffee-machine lab design.

## Interface
Parameters:
- STEP_CYCLES, 4: clock cycles each ingredient output stays asserted.
- READY_CYCLES, 4: clock cycles `bebidaLista` stays asserted.

Ports:
- clk_50Mhz  in  1  system clock, 50 MHz. Single clock domain.
- rst  in  1  asynchronous, active-low reset.
- e  in  1  select espresso.
- l  in  1  select latte.
- x  in  1  select hot chocolate.
- m  in  1  select mocha.
- a  in  1  add sugar. Level, sampled when a selection is accepted.
- C  in  1  100-colón coin present. Level; counted on its rising edge.
- Q  in  1  500-colón coin present. Level; counted on its rising edge.
- bebidaLista  out  1  drink finished.
- agua, cafe, leche, choco, azucar  out  1 each  ingredient valve drives.
- hex1  out  7  tens digit of credit/100. Active-low segments, bit order {g,f,e,d,c,b,a}.
- hex2  out  7  units digit of credit/100. Same encoding.

## Operation
- Credit register: 7 bits, unit = 100 colones, range 0..99.
- Coin counting:
  - C rising edge adds 1. Q rising edge adds 5.
  - A coin that would push credit above 99 is ignored.
  - If C and Q both rise in the same cycle, both are counted (+6, subject to the same limit).
  - Coins are accepted in every state, including while dispensing.
- Edge detection: one register per input holds its previous value. Inputs are assumed synchronous to `clk_50Mhz`.
- Prices (credit units) and recipes, with steps in this order:
  - e: price 6; steps AGUA, CAFE.
  - l: price 8; steps AGUA, CAFE, LECHE.
  - x: price 5; steps AGUA, CHOCO.
  - m: price 10; steps AGUA, CAFE, LECHE, CHOCO.
  - If `a`=1 at acceptance, an AZUCAR step is appended. Sugar is free.
- Selection:
  - Only in IDLE, on the rising edge of a selection input.
  - Simultaneous edges are resolved by priority e > l > x > m.
  - Credit below the price: the selection is ignored and the machine stays in IDLE.
  - Credit at or above the price: the price is subtracted in the same cycle. No change is returned and the remainder stays as credit.
  - Selections arriving outside IDLE are ignored.
- FSM states: IDLE, AGUA, CAFE, LECHE, CHOCO, AZUCAR, LISTO.
  - Each ingredient state lasts STEP_CYCLES, then moves to the next recipe step.
  - After the last step the FSM enters LISTO.
  - LISTO lasts READY_CYCLES, then returns to IDLE.
- Outputs are Moore, registered, and one-hot:
  - Each ingredient output is 1 only in its own state.
  - `bebidaLista` is 1 only in LISTO.
  - All are 0 in IDLE.
- Display: `hex1` = credit/10 and `hex2` = credit%10 in 7-segment encoding. A leading zero is shown. Example: credit 7 gives `hex1`=7'b1000000 and `hex2`=7'b1111000.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE, credit to 0, step counter to 0, edge registers to 0.
  - All drive outputs and `bebidaLista` are 0.
  - `hex1` and `hex2` both show 0 (7'b1000000).
  - Reset during dispensing aborts the drink and clears the credit.
- Coin latency: credit updates on the first clock edge that samples the coin input at 1. The display reflects it in the same cycle, combinationally from the credit register.
- Holding a coin or selection input high for many cycles counts once. The input must return to 0 before the next count.
- Selection latency: an accepted selection leaves AGUA asserted from the next clock edge. Credit is debited on that same edge.
- Total drink duration: (number of steps × STEP_CYCLES) + READY_CYCLES cycles, then IDLE.

## Structure
- Package `maquina_cafe_pkg`:
  - State enum.
  - Price constants PRICE_E=6, PRICE_L=8, PRICE_X=5, PRICE_M=10.
  - Recipe step-mask constants.
  - Coin values C_VAL=1, Q_VAL=5.
  - Constant CREDIT_MAX=99.
- Sub-module `hex7seg`: 4-bit digit in, 7-bit active-low segments out. Instantiated twice.
- The FSM, credit register, and edge detectors stay in the top module.

## Test plan
- Reset: rst=0 -> all outputs 0, `hex1` and `hex2` = 7'b1000000.
- Coin accumulation: C, then Q, then C pulses (each held 2 cycles) -> credit 7; `hex2` = 7'b1111000.
- Espresso purchase: from credit 7, pulse e with a=0.
  - AGUA for 4 cycles, then CAFE for 4, then `bebidaLista` for 4, then IDLE.
  - Credit ends at 1.
- Insufficient credit: credit 1, pulse m -> no outputs, credit stays 1.
- Mocha with sugar and a mid-sequence coin: credit 15, a=1, pulse m.
  - Sequence AGUA, CAFE, LECHE, CHOCO, AZUCAR, LISTO.
  - Credit 5 after debit, 10 after Q is inserted mid-sequence.
- Saturation and priority:
  - Credit 97 plus Q -> credit stays 97.
  - e and l rising together with credit 10 -> espresso is served and credit ends at 4.
